// File: rtl/rgb888_pkg.sv
`default_nettype none
// rgb888_pkg: shared types and rgb_enable encodings for the RGB888 pixel scheduler.
package rgb888_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_t;

    typedef logic [23:0] pixel_t;

    localparam logic [1:0] RGB_EN_NONE    = 2'b00;
    localparam logic [1:0] RGB_EN_ONE     = 2'b01;
    localparam logic [1:0] RGB_EN_TWO     = 2'b11;
    localparam logic [1:0] RGB_EN_ILLEGAL = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rgb888_pixel_scheduler_fifo.sv
`default_nettype none
// pixel_fifo_2w1r: FIFO accepting up to two pixels per cycle and delivering one.
module pixel_fifo_2w1r
    import rgb888_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic                       wr_two_i,
    input  pixel_t                     wr_data0_i,
    input  pixel_t                     wr_data1_i,
    input  logic                       rd_en_i,
    output pixel_t                     rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pixel_t          mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   wr_n;

    assign wr_n = wr_en_i ? (wr_two_i ? CW'(2) : CW'(1)) : '0;

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en_i) begin
                wptr_q <= wptr_q + (wr_two_i ? AW'(2) : AW'(1));
            end
            if (rd_en_i) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + wr_n - CW'(rd_en_i);
        end
    end

    // Storage needs no reset: the output is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wptr_q] <= wr_data0_i;
            if (wr_two_i) begin
                mem_q[wptr_q + AW'(1)] <= wr_data1_i;
            end
        end
    end

    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule
`default_nettype wire

// File: rtl/rgb888_pixel_scheduler.sv
`default_nettype none
// rgb888_pixel_scheduler: buffers decoded RGB888 pixels per CSI line and tracks
// output coordinates, line length and protocol errors.
module rgb888_pixel_scheduler
    import rgb888_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        line_end,
    input  logic [47:0] rgb,
    input  logic [1:0]  rgb_enable,
    output logic        decoder_restart,
    output logic [23:0] pixel,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [15:0] pixel_x,
    output logic [15:0] pixel_y,
    output logic        pixel_last,
    output logic        overflow,
    output logic        protocol_error,
    output logic        line_length_error
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] LAST_X   = 16'(LINE_WIDTH - 1);
    localparam logic [15:0] LINE_LEN = 16'(LINE_WIDTH);

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [15:0]   x_q;
    logic [15:0]   y_q;
    logic          restart_q;
    logic          ovf_q;
    logic          perr_q;
    logic          lle_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    pixel_t        fifo_head;

    logic          w_xfer;
    logic [1:0]    w_n_in;
    logic          w_active;
    logic [CW-1:0] w_free;
    logic          w_fits;
    logic          w_wr_en;
    logic          w_drop;
    logic [16:0]   w_cnt_sum;
    logic [15:0]   w_cnt_d;

    assign w_xfer   = !fifo_empty && pixel_ready;
    assign w_n_in   = (rgb_enable == RGB_EN_ONE) ? 2'd1 :
                      (rgb_enable == RGB_EN_TWO) ? 2'd2 : 2'd0;
    assign w_active = (state_q == ST_ACTIVE);
    // Free space is judged on occupancy before this cycle's read.
    assign w_free   = CW'(FIFO_DEPTH) - fifo_count;
    assign w_fits   = (CW'(w_n_in) <= w_free);
    assign w_wr_en  = w_active && !frame_start && (w_n_in != 2'd0) && w_fits;
    assign w_drop   = w_active && !frame_start && (w_n_in != 2'd0) && !w_fits;

    // Line input count restarts on a repeated line header and saturates.
    assign w_cnt_sum = {1'b0, (line_start ? 16'd0 : cnt_q)} + 17'(w_n_in);
    assign w_cnt_d   = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

    pixel_fifo_2w1r #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (frame_start),
        .wr_en_i    (w_wr_en),
        .wr_two_i   (rgb_enable == RGB_EN_TWO),
        .wr_data0_i (rgb[23:0]),
        .wr_data1_i (rgb[47:24]),
        .rd_en_i    (w_xfer),
        .rd_data_o  (fifo_head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            restart_q <= 1'b0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
            lle_q     <= 1'b0;
        end else begin
            restart_q <= 1'b0;
            if (w_xfer) begin
                if (x_q == LAST_X) begin
                    x_q <= '0;
                    y_q <= y_q + 16'd1;
                end else begin
                    x_q <= x_q + 16'd1;
                end
            end
            if ((rgb_enable == RGB_EN_ILLEGAL) || ((w_n_in != 2'd0) && !w_active)) begin
                perr_q <= 1'b1;
            end
            if (w_drop) begin
                ovf_q <= 1'b1;
            end
            if (w_active) begin
                cnt_q <= w_cnt_d;
            end
            // frame_start overrides every other control input in the same cycle.
            if (frame_start) begin
                state_q <= ST_WAIT_LINE;
                cnt_q   <= '0;
                x_q     <= '0;
                y_q     <= '0;
            end else begin
                case (state_q)
                    ST_WAIT_LINE: begin
                        if (line_start) begin
                            state_q   <= ST_ACTIVE;
                            cnt_q     <= '0;
                            restart_q <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (line_start) begin
                            lle_q     <= 1'b1;
                            restart_q <= 1'b1;
                        end else if (line_end) begin
                            state_q <= ST_WAIT_LINE;
                            if (cnt_q != LINE_LEN) begin
                                lle_q <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign decoder_restart   = restart_q;
    assign pixel             = fifo_head;
    assign pixel_valid       = !fifo_empty;
    assign pixel_x           = x_q;
    assign pixel_y           = y_q;
    assign pixel_last        = (x_q == LAST_X);
    assign overflow          = ovf_q;
    assign protocol_error    = perr_q;
    assign line_length_error = lle_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb888_pixel_scheduler.sv
`default_nettype none
// tb_rgb888_pixel_scheduler: directed and randomized checks against a queue-based model.
module tb_rgb888_pixel_scheduler;

    localparam int LW    = 640;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0, line_start = 1'b0, line_end = 1'b0;
    logic [47:0] rgb = '0;
    logic [1:0]  rgb_enable = 2'b00;
    logic        pixel_ready = 1'b0;
    logic        decoder_restart, pixel_valid, pixel_last;
    logic        overflow, protocol_error, line_length_error;
    logic [23:0] pixel;
    logic [15:0] pixel_x, pixel_y;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: 0 idle, 1 waiting for line, 2 inside line.
    int          m_state = 0;
    logic [23:0] m_q[$];
    int          m_x = 0, m_y = 0, m_cnt = 0;
    bit          m_ovf = 0, m_perr = 0, m_lle = 0, m_rst = 0;

    rgb888_pixel_scheduler #(.LINE_WIDTH(LW), .FIFO_DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .frame_start       (frame_start),
        .line_start        (line_start),
        .line_end          (line_end),
        .rgb               (rgb),
        .rgb_enable        (rgb_enable),
        .decoder_restart   (decoder_restart),
        .pixel             (pixel),
        .pixel_valid       (pixel_valid),
        .pixel_ready       (pixel_ready),
        .pixel_x           (pixel_x),
        .pixel_y           (pixel_y),
        .pixel_last        (pixel_last),
        .overflow          (overflow),
        .protocol_error    (protocol_error),
        .line_length_error (line_length_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        int n, cnt_pre;
        bit xfer;
        @(posedge clock);
        xfer    = (m_q.size() != 0) && pixel_ready;
        cnt_pre = m_cnt;
        if (reset) begin
            m_state = 0; m_q.delete(); m_x = 0; m_y = 0; m_cnt = 0;
            m_ovf = 0; m_perr = 0; m_lle = 0; m_rst = 0;
        end else begin
            n = (rgb_enable == 2'b01) ? 1 : (rgb_enable == 2'b11) ? 2 : 0;
            if (rgb_enable == 2'b10 || (n != 0 && m_state != 2)) m_perr = 1;
            if (m_state == 2 && n != 0 && !frame_start) begin
                if (DEPTH - m_q.size() < n) m_ovf = 1;
                else begin
                    m_q.push_back(rgb[23:0]);
                    if (n == 2) m_q.push_back(rgb[47:24]);
                end
            end
            if (xfer) begin
                void'(m_q.pop_front());
                if (m_x == LW - 1) begin m_x = 0; m_y = (m_y + 1) % 65536; end
                else m_x++;
            end
            if (m_state == 2) m_cnt = ((line_start ? 0 : m_cnt) + n > 65535) ? 65535 : (line_start ? 0 : m_cnt) + n;
            m_rst = !frame_start && line_start && m_state != 0;
            if (frame_start) begin
                m_state = 1; m_q.delete(); m_x = 0; m_y = 0; m_cnt = 0;
            end else if (m_state == 1 && line_start) begin
                m_state = 2; m_cnt = 0;
            end else if (m_state == 2 && line_start) begin
                m_lle = 1;
            end else if (m_state == 2 && line_end) begin
                if (cnt_pre != LW) m_lle = 1;
                m_state = 1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic fs, input logic ls, input logic le,
                         input logic [1:0] en, input logic [47:0] d);
        frame_start = fs; line_start = ls; line_end = le; rgb_enable = en; rgb = d;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 2'b00, '0);
        reset = 1'b0;
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic test_reset();
        pixel_ready = 1'b1;
        do_reset();
        n_checks++;
        if ({pixel_valid, pixel, pixel_x, pixel_y, pixel_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_datapath: got valid=%b pixel=%h x=%0d y=%0d last=%b, want all 0",
                     pixel_valid, pixel, pixel_x, pixel_y, pixel_last);
        end
        n_checks++;
        if ({decoder_restart, overflow, protocol_error, line_length_error} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 0000",
                     {decoder_restart, overflow, protocol_error, line_length_error});
        end
    endtask

    task automatic test_full_line();
        logic [23:0] sent[$];
        logic [47:0] d;
        int k = 0;
        do_reset();
        pixel_ready = 1'b1;
        drive(1, 0, 0, 2'b00, '0);
        drive(0, 1, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        for (int c = 0; c < 800; c++) begin
            if (c < 640 && c % 2 == 0) begin
                d = rnd48();
                sent.push_back(d[23:0]);
                sent.push_back(d[47:24]);
                drive(0, 0, 0, 2'b11, d);
            end else if (c == 640) begin
                drive(0, 0, 1, 2'b00, '0);
            end else begin
                drive(0, 0, 0, 2'b00, '0);
            end
            if (pixel_valid) begin
                n_checks++;
                if (k >= sent.size() || pixel !== sent[k] || pixel_x !== 16'(k) || pixel_last !== (k == LW - 1)) begin
                    n_fail++;
                    $display("FAIL full_line_pixel %0d: got pixel=%h x=%0d last=%b, want pixel=%h x=%0d last=%b",
                             k, pixel, pixel_x, pixel_last, (k < sent.size()) ? sent[k] : 24'h0, k, (k == LW - 1));
                end
                k++;
            end
            if (k >= 640 && c > 640) break;
        end
        drive(0, 0, 0, 2'b00, '0);
        n_checks++;
        if (k != 640 || pixel_y !== 16'd1 || pixel_x !== 16'd0 || pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_line_end: got count=%0d x=%0d y=%0d valid=%b, want 640 0 1 0",
                     k, pixel_x, pixel_y, pixel_valid);
        end
        n_checks++;
        if ({overflow, protocol_error, line_length_error} !== 3'b000) begin
            n_fail++;
            $display("FAIL full_line_errors: got %b, want 000", {overflow, protocol_error, line_length_error});
        end
    endtask

    task automatic test_overflow();
        logic [23:0] sent[$];
        logic [47:0] d;
        int k = 0;
        do_reset();
        pixel_ready = 1'b0;
        drive(1, 0, 0, 2'b00, '0);
        drive(0, 1, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        for (int w = 0; w < 320; w++) begin
            d = rnd48();
            sent.push_back(d[23:0]);
            sent.push_back(d[47:24]);
            drive(0, 0, 0, 2'b11, d);
            if (w == 3 || w == 4) begin
                n_checks++;
                if (overflow !== (w == 4)) begin
                    n_fail++;
                    $display("FAIL overflow_write%0d: got overflow=%b, want %b", w + 1, overflow, (w == 4));
                end
            end
        end
        drive(0, 0, 1, 2'b00, '0);
        n_checks++;
        if (line_length_error !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flags: got lle=%b ovf=%b, want 0 1", line_length_error, overflow);
        end
        pixel_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (pixel_valid) begin
                n_checks++;
                if (k >= 8 || pixel !== sent[k]) begin
                    n_fail++;
                    $display("FAIL overflow_drain %0d: got %h, want %h", k, pixel, (k < 8) ? sent[k] : 24'h0);
                end
                k++;
            end
            drive(0, 0, 0, 2'b00, '0);
        end
        n_checks++;
        if (k != 8) begin
            n_fail++;
            $display("FAIL overflow_count: got %0d pixels, want 8", k);
        end
    endtask

    task automatic test_restart();
        do_reset();
        pixel_ready = 1'b1;
        drive(0, 1, 0, 2'b00, '0);
        n_checks++;
        if (decoder_restart !== 1'b0) begin
            n_fail++; $display("FAIL restart_idle: got %b, want 0", decoder_restart);
        end
        drive(1, 0, 0, 2'b00, '0);
        drive(0, 1, 0, 2'b00, '0);
        n_checks++;
        if (decoder_restart !== 1'b1) begin
            n_fail++; $display("FAIL restart_wait: got %b, want 1", decoder_restart);
        end
        drive(0, 0, 0, 2'b00, '0);
        n_checks++;
        if (decoder_restart !== 1'b0) begin
            n_fail++; $display("FAIL restart_pulse_width: got %b, want 0", decoder_restart);
        end
        drive(0, 0, 0, 2'b01, rnd48());
        drive(0, 1, 0, 2'b00, '0);
        n_checks++;
        if (decoder_restart !== 1'b1 || line_length_error !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_active: got restart=%b lle=%b, want 1 1", decoder_restart, line_length_error);
        end
        drive(0, 0, 0, 2'b00, '0);
        n_checks++;
        if (decoder_restart !== 1'b0) begin
            n_fail++; $display("FAIL restart_active_width: got %b, want 0", decoder_restart);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        pixel_ready = 1'b0;
        drive(1, 0, 0, 2'b00, '0);
        drive(0, 1, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        n_checks++;
        if (protocol_error !== 1'b0) begin
            n_fail++; $display("FAIL protocol_clean: got %b, want 0", protocol_error);
        end
        drive(0, 0, 0, 2'b10, rnd48());
        n_checks++;
        if (protocol_error !== 1'b1 || pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL protocol_illegal: got perr=%b valid=%b, want 1 0", protocol_error, pixel_valid);
        end
        do_reset();
        drive(1, 0, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b01, rnd48());
        n_checks++;
        if (protocol_error !== 1'b1 || pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL protocol_outside_line: got perr=%b valid=%b, want 1 0", protocol_error, pixel_valid);
        end
    endtask

    task automatic test_length_flush();
        do_reset();
        pixel_ready = 1'b1;
        drive(1, 0, 0, 2'b00, '0);
        drive(0, 1, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        for (int i = 0; i < LW - 1; i++) drive(0, 0, 0, 2'b01, rnd48());
        n_checks++;
        if (line_length_error !== 1'b0) begin
            n_fail++; $display("FAIL short_line_before_end: got %b, want 0", line_length_error);
        end
        drive(0, 0, 1, 2'b00, '0);
        n_checks++;
        if (line_length_error !== 1'b1) begin
            n_fail++; $display("FAIL short_line: got lle=%b, want 1", line_length_error);
        end
        drive(0, 1, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        pixel_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 2'b01, rnd48());
        n_checks++;
        if (pixel_valid !== 1'b1 || pixel_x !== 16'(LW - 1) || pixel_last !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: got valid=%b x=%0d last=%b, want 1 %0d 1", pixel_valid, pixel_x, pixel_last, LW - 1);
        end
        drive(1, 0, 0, 2'b00, '0);
        n_checks++;
        if (pixel_valid !== 1'b0 || pixel_x !== 16'd0 || pixel_y !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_flush: got valid=%b x=%0d y=%0d, want 0 0 0", pixel_valid, pixel_x, pixel_y);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        pixel_ready = 1'b0;
        drive(1, 0, 0, 2'b00, '0);
        drive(0, 1, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b00, '0);
        drive(0, 0, 0, 2'b10, rnd48());
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 2'b01, rnd48());
        n_checks++;
        if (pixel_valid !== 1'b1 || protocol_error !== 1'b1) begin
            n_fail++; $display("FAIL midreset_setup: got valid=%b perr=%b, want 1 1", pixel_valid, protocol_error);
        end
        reset = 1'b1;
        drive(1, 1, 0, 2'b01, rnd48());
        reset = 1'b0;
        n_checks++;
        if ({pixel_valid, pixel, pixel_x, pixel_y, pixel_last, decoder_restart,
             overflow, protocol_error, line_length_error} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got valid=%b pixel=%h x=%0d y=%0d last=%b rst=%b ovf=%b perr=%b lle=%b, want all 0",
                     pixel_valid, pixel, pixel_x, pixel_y, pixel_last, decoder_restart,
                     overflow, protocol_error, line_length_error);
        end
        drive(0, 1, 0, 2'b00, '0);
        n_checks++;
        if (decoder_restart !== 1'b0) begin
            n_fail++; $display("FAIL midreset_idle: got restart=%b, want 0", decoder_restart);
        end
    endtask

    task automatic test_random();
        logic [1:0] en;
        int r, len;
        do_reset();
        drive(1, 0, 0, 2'b00, '0);
        for (int l = 0; l < 8; l++) begin
            len = $urandom_range(8, 40);
            for (int c = 0; c < len + 8; c++) begin
                pixel_ready = 1'($urandom);
                r  = $urandom_range(0, 15);
                en = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b11 : 2'b10;
                if (c < 3 || c >= len + 3) en = 2'b00;
                drive((l == 5 && c == 10), (c == 0), (c == len + 4), en, rnd48());
                n_checks++;
                if (pixel_valid !== (m_q.size() != 0) || (m_q.size() != 0 && pixel !== m_q[0])) begin
                    n_fail++;
                    $display("FAIL random_pixel l%0d c%0d: got valid=%b pixel=%h, want valid=%b pixel=%h",
                             l, c, pixel_valid, pixel, (m_q.size() != 0), (m_q.size() != 0) ? m_q[0] : 24'h0);
                end
                n_checks++;
                if (pixel_x !== 16'(m_x) || pixel_y !== 16'(m_y) || pixel_last !== (m_x == LW - 1)) begin
                    n_fail++;
                    $display("FAIL random_coord l%0d c%0d: got x=%0d y=%0d last=%b, want %0d %0d %b",
                             l, c, pixel_x, pixel_y, pixel_last, m_x, m_y, (m_x == LW - 1));
                end
                n_checks++;
                if ({decoder_restart, overflow, protocol_error, line_length_error} !== {m_rst, m_ovf, m_perr, m_lle}) begin
                    n_fail++;
                    $display("FAIL random_flags l%0d c%0d: got %b, want %b", l, c,
                             {decoder_restart, overflow, protocol_error, line_length_error},
                             {m_rst, m_ovf, m_perr, m_lle});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_overflow();
        test_restart();
        test_protocol();
        test_length_flush();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
